otter_int_ctrl: RTL and testbench

OTTER_INT_CTRL -- requirements
Module: otter_int_ctrl

---
 rtl/otter_int_ctrl_if.sv | 31 +++
 rtl/otter_int_ctrl.sv | 109 ++++++++++
 tb/tb_otter_int_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/otter_int_ctrl_if.sv
// Signal bundle between the OTTER pipeline/CSR unit and the interrupt controller.
// master = pipeline/CSR side, slave = otter_int_ctrl.
interface otter_int_ctrl_if;
  logic        INTR;
  logic        CSR_MIE;
  logic [31:0] CSR_MTVEC;
  logic [31:0] CSR_MEPC;
  logic        EX_VALID;
  logic [31:0] EX_PC;
  logic        EX_IS_MRET;
  logic [31:0] FETCH_PC;
  logic        MEM_BUSY;

  logic        STALL;
  logic        FLUSH;
  logic        INT_TAKEN;
  logic [31:0] INT_PC;
  logic        PC_REDIRECT;
  logic [31:0] PC_TARGET;
  logic        IN_HANDLER;

  modport master (
    output INTR, CSR_MIE, CSR_MTVEC, CSR_MEPC, EX_VALID, EX_PC, EX_IS_MRET, FETCH_PC, MEM_BUSY,
    input  STALL, FLUSH, INT_TAKEN, INT_PC, PC_REDIRECT, PC_TARGET, IN_HANDLER
  );

  modport slave (
    input  INTR, CSR_MIE, CSR_MTVEC, CSR_MEPC, EX_VALID, EX_PC, EX_IS_MRET, FETCH_PC, MEM_BUSY,
    output STALL, FLUSH, INT_TAKEN, INT_PC, PC_REDIRECT, PC_TARGET, IN_HANDLER
  );
endinterface

// File: rtl/otter_int_ctrl.sv
// OTTER external-interrupt controller: synchronizes INTR, drains the pipeline and issues trap/mret redirects.
// Define OTTER_INT_EDGE_EN for edge-triggered requests; default build is level-triggered.
module otter_int_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic             CLK,
  input logic             RST_N,
  otter_int_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TRAP, ST_HANDLER} state_t;

  localparam logic [3:0] DRAIN = 4'(DRAIN_CYCLES);

  state_t      state, state_nxt;
  logic        int_meta, int_sync, pending, req;
  logic [3:0]  drain_cnt, drain_nxt;
  logic [31:0] cap_pc, cap_nxt, pc_target_q;
  logic        stall_q, flush_q, taken_q, redirect_q, handler_q;
  logic        ex_mret, mret_hit, trap_nxt;

`ifdef OTTER_INT_EDGE_EN
  logic int_sync_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) int_sync_d <= 1'b0;
    else        int_sync_d <= int_sync;
  end

  assign req = int_sync & ~int_sync_d;
`else
  assign req = int_sync;
`endif

  assign ex_mret  = bus.EX_VALID & bus.EX_IS_MRET;
  // EX is being killed while FLUSH is high, so an mret still sitting there is the same event
  assign mret_hit = ex_mret & (state != ST_TRAP) & ~flush_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    cap_nxt   = cap_pc;
    if (bus.EX_VALID)            drain_nxt = 4'd0;
    else if (drain_cnt >= DRAIN) drain_nxt = drain_cnt;
    else                         drain_nxt = drain_cnt + 4'd1;

    case (state)
      ST_IDLE: if (pending && bus.CSR_MIE) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!bus.CSR_MIE) begin
          state_nxt = ST_IDLE;
        end else if (!ex_mret && !bus.MEM_BUSY) begin
          if (bus.EX_VALID) begin
            state_nxt = ST_TRAP;
            cap_nxt   = bus.EX_PC;
          end else if (drain_nxt == DRAIN) begin
            state_nxt = ST_TRAP;
            cap_nxt   = bus.FETCH_PC;
          end
        end
      end
      ST_TRAP:    state_nxt = ST_HANDLER;
      ST_HANDLER: if (mret_hit) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign trap_nxt = (state_nxt == ST_TRAP);

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!RST_N) begin
      int_meta    <= 1'b0;
      int_sync    <= 1'b0;
      pending     <= 1'b0;
      state       <= ST_IDLE;
      drain_cnt   <= 4'd0;
      cap_pc      <= 32'h0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      taken_q     <= 1'b0;
      redirect_q  <= 1'b0;
      handler_q   <= 1'b0;
      pc_target_q <= 32'h0;
    end else begin
      int_meta    <= bus.INTR;
      int_sync    <= int_meta;
      pending     <= (state == ST_TRAP) ? 1'b0 : (pending | req);
      state       <= state_nxt;
      drain_cnt   <= (state == ST_WAIT) ? drain_nxt : 4'd0;
      cap_pc      <= cap_nxt;
      stall_q     <= (state_nxt == ST_WAIT) || trap_nxt;
      flush_q     <= trap_nxt || mret_hit;
      taken_q     <= trap_nxt;
      redirect_q  <= trap_nxt || mret_hit;
      handler_q   <= (state_nxt == ST_HANDLER);
      if (trap_nxt)      pc_target_q <= bus.CSR_MTVEC;
      else if (mret_hit) pc_target_q <= bus.CSR_MEPC;
      else               pc_target_q <= 32'h0;
    end
  end

  assign bus.STALL       = stall_q;
  assign bus.FLUSH       = flush_q;
  assign bus.INT_TAKEN   = taken_q;
  assign bus.PC_REDIRECT = redirect_q;
  assign bus.IN_HANDLER  = handler_q;
  assign bus.PC_TARGET   = pc_target_q;
  assign bus.INT_PC      = (state == ST_TRAP) ? cap_pc : 32'h0;
endmodule

// File: tb/tb_otter_int_ctrl.sv
// Directed self-checking bench for otter_int_ctrl (DRAIN_CYCLES = 3); follows OTTER_INT_EDGE_EN if defined.
module tb_otter_int_ctrl;
  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

`ifdef OTTER_INT_EDGE_EN
  localparam bit EDGE_BUILD = 1'b1;
`else
  localparam bit EDGE_BUILD = 1'b0;
`endif

  otter_int_ctrl_if bus ();

  otter_int_ctrl #(.DRAIN_CYCLES(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic stall, input logic flush, input logic taken,
                           input logic redir, input logic inh, input logic [31:0] tgt,
                           input logic [31:0] ipc);
    check({tag, ".stall"},      32'(bus.STALL),       32'(stall));
    check({tag, ".flush"},      32'(bus.FLUSH),       32'(flush));
    check({tag, ".int_taken"},  32'(bus.INT_TAKEN),   32'(taken));
    check({tag, ".redirect"},   32'(bus.PC_REDIRECT), 32'(redir));
    check({tag, ".in_handler"}, 32'(bus.IN_HANDLER),  32'(inh));
    check({tag, ".pc_target"},  bus.PC_TARGET,        tgt);
    check({tag, ".int_pc"},     bus.INT_PC,           ipc);
  endtask

  // One-cycle INTR pulse; afterwards pending is set but the FSM is still IDLE.
  task automatic pulse_intr(input string tag);
    bus.INTR = 1'b1;
    tick();
    bus.INTR = 1'b0;
    tick();
    tick();
    check({tag, ".pre_wait_stall"}, 32'(bus.STALL), 32'h0);
  endtask

  task automatic do_mret(input string tag, input logic [31:0] mepc, input logic ev_after);
    bus.EX_VALID   = 1'b1;
    bus.EX_IS_MRET = 1'b1;
    bus.CSR_MEPC   = mepc;
    tick();
    check_out(tag, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mepc, 32'h0);
    bus.EX_IS_MRET = 1'b0;
    bus.EX_VALID   = ev_after;
    tick();
    check_out({tag, "_after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    RST_N          = 1'b0;
    bus.INTR       = 1'b0;
    bus.CSR_MIE    = 1'b0;
    bus.CSR_MTVEC  = 32'h200;
    bus.CSR_MEPC   = 32'h0;
    bus.EX_VALID   = 1'b0;
    bus.EX_PC      = 32'h0;
    bus.EX_IS_MRET = 1'b0;
    bus.FETCH_PC   = 32'h0;
    bus.MEM_BUSY   = 1'b0;
    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    RST_N        = 1'b1;
    bus.CSR_MIE  = 1'b1;
    bus.EX_VALID = 1'b1;
    bus.EX_PC    = 32'h100;
    tick();
    check_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Trap on a valid EX instruction, then mret back.
    pulse_intr("t1");
    tick();
    check_out("t1_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_out("t1_trap", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h100);
    tick();
    check_out("t1_handler", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    do_mret("t1_mret", 32'h100, 1'b0);

    // Empty pipeline: trap after three drain cycles with FETCH_PC as return address.
    bus.FETCH_PC = 32'h80;
    pulse_intr("t3");
    tick();
    check_out("t3_wait0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_out("t3_wait1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_out("t3_wait2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_out("t3_trap", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h80);
    tick();
    check_out("t3_handler", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    do_mret("t3_mret", 32'h80, 1'b1);

    // MEM_BUSY holds WAIT for five cycles.
    bus.EX_PC    = 32'h140;
    bus.MEM_BUSY = 1'b1;
    pulse_intr("t4");
    tick();
    check_out("t4_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("t4_busy", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    bus.MEM_BUSY = 1'b0;
    tick();
    check_out("t4_trap", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h140);
    tick();
    check_out("t4_handler", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    do_mret("t4_mret", 32'h140, 1'b1);

    // MIE falls in WAIT: back to IDLE with pending kept, then trap once MIE returns.
    bus.EX_PC    = 32'h150;
    bus.MEM_BUSY = 1'b1;
    pulse_intr("t6");
    tick();
    check_out("t6_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.CSR_MIE = 1'b0;
    tick();
    check_out("t6_mie_off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_out("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.CSR_MIE  = 1'b1;
    bus.MEM_BUSY = 1'b0;
    tick();
    check_out("t6_rewait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_out("t6_trap", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h150);
    tick();
    check_out("t6_handler", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    do_mret("t6_mret", 32'h150, 1'b0);

    // mret while in WAIT: redirect to MEPC, WAIT held, trap on the next real instruction.
    pulse_intr("t7");
    tick();
    check_out("t7_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.EX_VALID   = 1'b1;
    bus.EX_IS_MRET = 1'b1;
    bus.CSR_MEPC   = 32'h300;
    tick();
    check_out("t7_mret", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    bus.EX_IS_MRET = 1'b0;
    bus.EX_PC      = 32'h1C0;
    tick();
    check_out("t7_trap", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h1C0);
    tick();
    check_out("t7_handler", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    do_mret("t7_mret2", 32'h1C0, 1'b1);

    // MIE=0 with INTR held: no stall; MIE=1 traps; held INTR re-traps only in the level build.
    bus.CSR_MIE = 1'b0;
    bus.EX_PC   = 32'h180;
    bus.INTR    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("t5_masked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    bus.CSR_MIE = 1'b1;
    tick();
    check_out("t5_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_out("t5_trap", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h180);
    tick();
    check_out("t5_handler", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    bus.EX_IS_MRET = 1'b1;
    bus.CSR_MEPC   = 32'h180;
    tick();
    check_out("t5_mret", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h180, 32'h0);
    bus.EX_IS_MRET = 1'b0;
    bus.INTR       = 1'b0;
    tick();
    check("t5_second_wait", 32'(bus.STALL), EDGE_BUILD ? 32'h0 : 32'h1);
    tick();
    check("t5_second_taken", 32'(bus.INT_TAKEN), EDGE_BUILD ? 32'h0 : 32'h1);
    check("t5_second_int_pc", bus.INT_PC, EDGE_BUILD ? 32'h0 : 32'h180);
    tick();
    check("t5_second_handler", 32'(bus.IN_HANDLER), EDGE_BUILD ? 32'h0 : 32'h1);
    do_mret("t5_mret2", 32'h180, 1'b1);

    // Reset in WAIT aborts the trap and clears pending.
    bus.EX_PC    = 32'h1E0;
    bus.MEM_BUSY = 1'b1;
    pulse_intr("t8");
    tick();
    check_out("t8_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    RST_N = 1'b0;
    tick();
    check_out("t8_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    RST_N        = 1'b1;
    bus.MEM_BUSY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t8_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
